alu_muldiv_seq: RTL

Iterative multiply/divide sequencer that borrows the shared ALU to implement MULTU/DIVU (and MULT/DIV when the optional feature is enabled), producing MIPS HI/LO results. It sits beside the execute-stage ALU. While busy it drives the ALU operand/opcode inputs through a select line into the execute-stage mux, then consumes the ALU result and overflow flag once per cycle. One ALU add or subtract is performed per iteration; all shifting is done in local registers.

---
 rtl/alu_muldiv_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative MIPS-style HI/LO multiply/divide sequencer. It borrows the execute-stage ALU for one add or subtract per step.
// Optional build macro MULDIV_SIGNED_EN adds signed MULT/DIV handling around the unsigned core.
`ifndef WIDTH
`define WIDTH 64
`endif

module alu_muldiv_seq #(
   parameter int WIDTH = `WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             p_CLK,
   input  logic             p_RST_N,
   input  logic             p_start,
   input  logic             p_isDiv,
   input  logic             p_signed,
   input  logic             p_flush,
   input  logic [WIDTH-1:0] p_opA,
   input  logic [WIDTH-1:0] p_opB,
   output logic             p_busy,
   output logic             p_done,
   output logic [WIDTH-1:0] p_HI,
   output logic [WIDTH-1:0] p_LO,
   output logic             p_aluSel,
   output logic [3:0]       p_aluOp,
   output logic [WIDTH-1:0] p_aluA,
   output logic [WIDTH-1:0] p_aluB,
   input  logic [WIDTH-1:0] p_aluR,
   input  logic             p_aluOVL
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [3:0] OP_ADD = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0111;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;          // multiplicand M or divisor D
   logic [WIDTH-1:0] hi_q, hi_d;        // P_hi or remainder R
   logic [WIDTH-1:0] lo_q, lo_d;        // P_lo or quotient Q
   logic [WIDTH-1:0] res_hi_q, res_lo_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;      // negate product / quotient at DONE
   logic             neg_r_q, neg_r_d;  // negate remainder at DONE

   logic [WIDTH-1:0] op_a, op_b;
   logic             sgn_a, sgn_b;
   logic [WIDTH-1:0] fin_hi, fin_lo;
   logic [WIDTH:0]   mul_sum;
   logic             div_take;

`ifdef MULDIV_SIGNED_EN
   assign sgn_a = p_signed & p_opA[WIDTH-1];
   assign sgn_b = p_signed & p_opB[WIDTH-1];
   assign op_a  = sgn_a ? -p_opA : p_opA;
   assign op_b  = sgn_b ? -p_opB : p_opB;
`else
   logic unused_signed;
   assign unused_signed = p_signed;
   assign sgn_a = 1'b0;
   assign sgn_b = 1'b0;
   assign op_a  = p_opA;
   assign op_b  = p_opB;
`endif

   always_comb begin
      fin_hi = hi_q;
      fin_lo = lo_q;
`ifdef MULDIV_SIGNED_EN
      if (div_q) begin
         if (neg_q)   fin_lo = -lo_q;
         if (neg_r_q) fin_hi = -hi_q;
      end else if (neg_q) begin
         {fin_hi, fin_lo} = -{hi_q, lo_q};
      end
`endif
   end

   assign p_busy   = (state_q != S_IDLE);
   assign p_aluSel = (state_q == S_MUL) || (state_q == S_DIV);
   assign p_aluOp  = (state_q == S_DIV) ? OP_SUB : OP_ADD;
   assign p_aluA   = (state_q == S_DIV) ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : hi_q;
   assign p_aluB   = m_q;
   // HI/LO become visible in the DONE cycle itself; a flush there leaves them untouched.
   assign p_done   = (state_q == S_DONE) && !p_flush;
   assign p_HI     = p_done ? fin_hi : res_hi_q;
   assign p_LO     = p_done ? fin_lo : res_lo_q;

   assign mul_sum  = lo_q[0] ? {p_aluOVL, p_aluR} : {1'b0, hi_q};
   assign div_take = hi_q[WIDTH-1] | ~p_aluOVL;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      neg_r_d = neg_r_q;
      case (state_q)
         S_IDLE: begin
            if (p_start && !p_flush) begin
               div_d   = p_isDiv;
               m_d     = op_b;
               hi_d    = '0;
               lo_d    = op_a;
               cnt_d   = CNT_W'(WIDTH);
               neg_d   = sgn_a ^ sgn_b;
               neg_r_d = sgn_a;
               if (p_isDiv && (p_opB == '0)) begin
                  hi_d    = p_opA;
                  lo_d    = '1;
                  neg_d   = 1'b0;
                  neg_r_d = 1'b0;
                  state_d = S_DONE;
               end else begin
                  state_d = p_isDiv ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (p_flush) begin
               state_d = S_IDLE;
            end else begin
               if (state_q == S_MUL) begin
                  hi_d = mul_sum[WIDTH:1];
                  lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
               end else begin
                  hi_d = div_take ? p_aluR : p_aluA;
                  lo_d = {lo_q[WIDTH-2:0], div_take};
               end
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; every register, including the datapath, resets asynchronously.
   always_ff @(posedge p_CLK or negedge p_RST_N) begin
      if (!p_RST_N) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= p_HI;
         res_lo_q <= p_LO;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         neg_q    <= neg_d;
         neg_r_q  <= neg_r_d;
      end
   end

endmodule
